// File: rtl/key_pkg.sv
// Shared key-handling definitions: debounce FSM encoding and
// the default stable-time filter length.
package key_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PRESS_DB   = 2'b01,
        PRESSED    = 2'b10,
        RELEASE_DB = 2'b11
    } key_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit, with a
// configurable reset level so idle inputs do not glitch on reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronizes the raw key, then requires a
// full stable window before changing level and pulsing press/release.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic key_value,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          key_sync;
    key_state_t    state;
    key_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          value_next;
    logic          press_next;
    logic          release_next;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .d    (key),
        .q    (key_sync)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            key_value   <= 1'b1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            key_value   <= value_next;
            key_press   <= press_next;
            key_release <= release_next;
        end
    end

    // The count restarts from zero on any bounce back to the stable level.
    always_comb begin
        state_next   = state;
        cnt_next     = '0;
        value_next   = 1'b1;
        press_next   = 1'b0;
        release_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (!key_sync) begin
                    state_next = PRESS_DB;
                    cnt_next   = CNT_ONE;
                end
            end
            PRESS_DB: begin
                if (key_sync) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    value_next = 1'b0;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                value_next = 1'b0;
                if (key_sync) begin
                    state_next = RELEASE_DB;
                    cnt_next   = CNT_ONE;
                end
            end
            RELEASE_DB: begin
                value_next = 1'b0;
                if (!key_sync) begin
                    state_next = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_next   = IDLE;
                    value_next   = 1'b1;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a run-length reference
// model of the debounced key level.
module tb_key_debounce;

    localparam int D = 10;

    logic clk;
    logic rst_n;
    logic key;
    logic key_value;
    logic key_press;
    logic key_release;

    int checks;
    int failures;

    bit q[$];
    int run;
    bit mv;
    bit mp;
    bit mr;

    key_debounce #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .key        (key),
        .key_value  (key_value),
        .key_press  (key_press),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One clock: drive at negedge, update model at posedge, return at negedge.
    // Model: the level seen two edges late must differ from the debounced
    // level for D consecutive edges before the debounced level follows it.
    task automatic step(input bit k, input bit r);
        bit s;
        key   = k;
        rst_n = r;
        @(posedge clk);
        if (!r) begin
            q   = {1'b1, 1'b1};
            run = 0;
            mv  = 1'b1;
            mp  = 1'b0;
            mr  = 1'b0;
        end else begin
            q.push_back(k);
            s  = q.pop_front();
            mp = 1'b0;
            mr = 1'b0;
            if (s != mv) run++;
            else run = 0;
            if (run == D) begin
                mv  = s;
                mp  = !s;
                mr  = s;
                run = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({key_value, key_press, key_release} !== 3'b100) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=100", i,
                         {key_value, key_press, key_release});
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if ({key_value, key_press, key_release} !== 3'b100) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%b exp=100", i,
                         {key_value, key_press, key_release});
            end
        end
    endtask

    task automatic test_clean_press();
        int fall_at;
        int presses;
        fall_at = 0;
        presses = 0;
        for (int i = 1; i <= 50; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if ({key_value, key_press, key_release} !== {mv, mp, mr}) begin
                failures++;
                $display("FAIL press_cycle i=%0d got=%b exp=%b", i,
                         {key_value, key_press, key_release}, {mv, mp, mr});
            end
            if (key_press) presses++;
            if (!key_value && fall_at == 0) fall_at = i;
        end
        checks++;
        if (fall_at != 12) begin
            failures++;
            $display("FAIL press_latency got=%0d exp=12", fall_at);
        end
        checks++;
        if (presses != 1) begin
            failures++;
            $display("FAIL press_count got=%0d exp=1", presses);
        end
    endtask

    task automatic test_release();
        int rise_at;
        int rels;
        int bad;
        bad = 0;
        for (int i = 0; i < 28; i++) begin
            step(i < 8 ? 1'b1 : 1'b0, 1'b1);
            checks++;
            if ({key_value, key_press, key_release} !== {mv, mp, mr}) begin
                failures++;
                $display("FAIL rel_glitch_cycle i=%0d got=%b exp=%b", i,
                         {key_value, key_press, key_release}, {mv, mp, mr});
            end
            if (key_value || key_press || key_release) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rel_glitch_quiet got=%0d exp=0", bad);
        end
        rise_at = 0;
        rels    = 0;
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if ({key_value, key_press, key_release} !== {mv, mp, mr}) begin
                failures++;
                $display("FAIL release_cycle i=%0d got=%b exp=%b", i,
                         {key_value, key_press, key_release}, {mv, mp, mr});
            end
            if (key_release) rels++;
            if (key_value && rise_at == 0) rise_at = i;
        end
        checks++;
        if (rise_at != 12 || rels != 1) begin
            failures++;
            $display("FAIL release_latency got=%0d/%0d exp=12/1",
                     rise_at, rels);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        for (int i = 0; i < 28; i++) begin
            step(i < 8 ? 1'b0 : 1'b1, 1'b1);
            checks++;
            if ({key_value, key_press, key_release} !== {mv, mp, mr}) begin
                failures++;
                $display("FAIL glitch_cycle i=%0d got=%b exp=%b", i,
                         {key_value, key_press, key_release}, {mv, mp, mr});
            end
            if (!key_value || key_press || key_release) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL glitch_quiet got=%0d exp=0", bad);
        end
    endtask

    task automatic test_bounce();
        int fall_at;
        int presses;
        fall_at = 0;
        presses = 0;
        for (int i = 0; i < 8; i++) begin
            step(i < 5 ? 1'b0 : 1'b1, 1'b1);
            if (key_press) presses++;
        end
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if ({key_value, key_press, key_release} !== {mv, mp, mr}) begin
                failures++;
                $display("FAIL bounce_cycle i=%0d got=%b exp=%b", i,
                         {key_value, key_press, key_release}, {mv, mp, mr});
            end
            if (key_press) presses++;
            if (!key_value && fall_at == 0) fall_at = i;
        end
        checks++;
        if (fall_at != 12 || presses != 1) begin
            failures++;
            $display("FAIL bounce_press got=%0d/%0d exp=12/1",
                     fall_at, presses);
        end
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int fall_at;
        int presses;
        int bad;
        fall_at = 0;
        presses = 0;
        bad     = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            if (!key_value || key_press || key_release) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_mid_hold got=%0d exp=0", bad);
        end
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1);
            if (key_press) presses++;
            if (!key_value && fall_at == 0) fall_at = i;
        end
        checks++;
        if (fall_at != 12 || presses != 1) begin
            failures++;
            $display("FAIL reset_mid_press got=%0d/%0d exp=12/1",
                     fall_at, presses);
        end
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    endtask

    task automatic test_random();
        bit lvl;
        int len;
        int n;
        lvl = 1'b1;
        n   = 0;
        while (n < 600) begin
            lvl = ~lvl;
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) begin
                step(lvl, 1'b1);
                n++;
                checks++;
                if ({key_value, key_press, key_release} !== {mv, mp, mr} ||
                    (key_press && key_release)) begin
                    failures++;
                    $display("FAIL random_cycle n=%0d got=%b exp=%b", n,
                             {key_value, key_press, key_release},
                             {mv, mp, mr});
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        q        = {1'b1, 1'b1};
        run      = 0;
        mv       = 1'b1;
        mp       = 1'b0;
        mr       = 1'b0;
        rst_n    = 1'b0;
        key      = 1'b1;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_release();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
